// File: rtl/trap_ctrl_pkg.sv
// Shared encodings and constants for the machine-mode trap controller.
package trap_ctrl_pkg;

   localparam int XLEN_DEF = 64;
   localparam int CNT_W_DEF = 32;

   localparam logic [63:0] MCAUSE_IRQ_DEF   = 64'h8000_0000_0000_0007;
   localparam logic [63:0] MCAUSE_ECALL_DEF = 64'd11;

   // Direct-mode mtvec: the low two bits select the mode and are not part of the base.
   localparam logic [63:0] MTVEC_ALIGN_MASK = ~64'h3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_UPDATE   = 2'd2,
      ST_REDIRECT = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_IRQ   = 2'd1,
      EV_ECALL = 2'd2,
      EV_MRET  = 2'd3
   } evt_e;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / return sequencer between commit, CSR file, fetch and LSU.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | accepting commits; detects irq/ecall/mret at commit
// ST_DRAIN    | pipeline flushed, waiting for outstanding LSU accesses
// ST_UPDATE   | single cycle: CSR trap-enter or trap-return strobe
// ST_REDIRECT | fetch redirect to captured target, held until accepted
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int               XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0]  MCAUSE_IRQ   = MCAUSE_IRQ_DEF[XLEN-1:0],
   parameter logic [XLEN-1:0]  MCAUSE_ECALL = MCAUSE_ECALL_DEF[XLEN-1:0],
   parameter int               CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   output logic             commit_ready,
   input  logic [XLEN-1:0]  commit_pc,
   input  logic             commit_ecall,
   input  logic             commit_mret,
   input  logic             irq_pending,
   output logic             commit_kill,
   output logic             flush,
   input  logic             mem_busy,
   output logic             csr_trap_enter,
   output logic             csr_trap_ret,
   output logic [XLEN-1:0]  csr_mepc_wdata,
   output logic [XLEN-1:0]  csr_mcause_wdata,
   input  logic [XLEN-1:0]  mtvec_i,
   input  logic [XLEN-1:0]  mepc_i,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             busy,
   output logic [CNT_W-1:0] trap_count
);

   localparam logic [XLEN-1:0] ALIGN_MASK = MTVEC_ALIGN_MASK[XLEN-1:0];

   state_e           state_q, state_d;
   evt_e             evt_q, evt_d;
   evt_e             det_evt;
   logic [XLEN-1:0]  epc_q, epc_d;
   logic [XLEN-1:0]  cause_q, cause_d;
   logic [XLEN-1:0]  target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Event priority at commit; a zero PC cannot be a resumable mepc, so irq waits for a real one.
   always_comb begin
      det_evt = EV_NONE;
      if (commit_valid) begin
         if (irq_pending && (commit_pc != '0)) det_evt = EV_IRQ;
         else if (commit_ecall)                det_evt = EV_ECALL;
         else if (commit_mret)                 det_evt = EV_MRET;
      end
   end

   // Next-state, latch updates and output decode for the trap sequence.
   always_comb begin
      state_d          = state_q;
      evt_d            = evt_q;
      epc_d            = epc_q;
      cause_d          = cause_q;
      target_d         = target_q;
      cnt_d            = cnt_q;
      commit_ready     = 1'b0;
      commit_kill      = 1'b0;
      flush            = 1'b0;
      csr_trap_enter   = 1'b0;
      csr_trap_ret     = 1'b0;
      csr_mepc_wdata   = '0;
      csr_mcause_wdata = '0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;

      case (state_q)
         ST_IDLE: begin
            commit_ready = 1'b1;
            if (det_evt != EV_NONE) begin
               flush       = 1'b1;
               // mret retires; the interrupted or ecall instruction does not.
               commit_kill = (det_evt != EV_MRET);
               evt_d       = det_evt;
               epc_d       = commit_pc;
               case (det_evt)
                  EV_IRQ:   cause_d = MCAUSE_IRQ;
                  EV_ECALL: cause_d = MCAUSE_ECALL;
                  default:  cause_d = '0;
               endcase
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            flush = 1'b1;
            if (!mem_busy) state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            flush = 1'b1;
            if (evt_q == EV_MRET) begin
               csr_trap_ret = 1'b1;
               target_d     = mepc_i;
            end else begin
               csr_trap_enter   = 1'b1;
               csr_mepc_wdata   = epc_q;
               csr_mcause_wdata = cause_q;
               target_d         = mtvec_i & ALIGN_MASK;
               cnt_d            = cnt_q + CNT_W'(1);
            end
            state_d = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = target_q;
            if (redirect_ready) begin
               state_d = ST_IDLE;
               evt_d   = EV_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy       = (state_q != ST_IDLE);
   assign trap_count = cnt_q;

   // State, event latches and trap counter; reset drops any in-flight event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         evt_q    <= EV_NONE;
         epc_q    <= '0;
         cause_q  <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         evt_q    <= evt_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of the trap rules.
module tb_trap_ctrl;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;
   localparam logic [63:0] CAUSE_IRQ   = 64'h8000_0000_0000_0007;
   localparam logic [63:0] CAUSE_ECALL = 64'd11;

   logic             clk;
   logic             rst;
   logic             commit_valid;
   logic             commit_ready;
   logic [XLEN-1:0]  commit_pc;
   logic             commit_ecall;
   logic             commit_mret;
   logic             irq_pending;
   logic             commit_kill;
   logic             flush;
   logic             mem_busy;
   logic             csr_trap_enter;
   logic             csr_trap_ret;
   logic [XLEN-1:0]  csr_mepc_wdata;
   logic [XLEN-1:0]  csr_mcause_wdata;
   logic [XLEN-1:0]  mtvec_i;
   logic [XLEN-1:0]  mepc_i;
   logic             redirect_valid;
   logic             redirect_ready;
   logic [XLEN-1:0]  redirect_pc;
   logic             busy;
   logic [CNT_W-1:0] trap_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   trap_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_ecall(commit_ecall), .commit_mret(commit_mret),
      .irq_pending(irq_pending), .commit_kill(commit_kill), .flush(flush),
      .mem_busy(mem_busy), .csr_trap_enter(csr_trap_enter), .csr_trap_ret(csr_trap_ret),
      .csr_mepc_wdata(csr_mepc_wdata), .csr_mcause_wdata(csr_mcause_wdata),
      .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .busy(busy), .trap_count(trap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Drive garbage on commit-side inputs that the controller must ignore while busy.
   task automatic scramble_commit();
      commit_valid = 1'($urandom_range(0, 1));
      commit_ecall = 1'($urandom_range(0, 1));
      commit_mret  = 1'($urandom_range(0, 1));
      irq_pending  = 1'($urandom_range(0, 1));
      commit_pc    = rnd64();
   endtask

   // One commit offered in IDLE, followed through the whole sequence.
   // nbusy: DRAIN cycles with mem_busy high; ndelay: REDIRECT cycles with ready low.
   task automatic run_txn(input logic [63:0] pc, input logic ec, input logic mr, input logic irq,
                          input int nbusy, input int ndelay,
                          input logic [63:0] mtvec, input logic [63:0] mepc);
      int ev;
      logic [63:0] exp_cause;
      logic [63:0] exp_tgt;
      ev = 0;
      if (irq && pc != 0) ev = 1;
      else if (ec)        ev = 2;
      else if (mr)        ev = 3;

      commit_valid = 1'b1; commit_pc = pc; commit_ecall = ec; commit_mret = mr;
      irq_pending = irq; mem_busy = 1'($urandom_range(0, 1)); redirect_ready = 1'b0;
      mtvec_i = mtvec; mepc_i = mepc;
      #1;
      chk("t_commit_ready", 64'(commit_ready), 64'd1);
      chk("t_commit_kill", 64'(commit_kill), 64'(ev == 1 || ev == 2));
      chk("t_flush", 64'(flush), 64'(ev != 0));
      chk("t_busy", 64'(busy), 64'd0);
      step();

      if (ev == 0) begin
         commit_valid = 1'b0;
         #1;
         chk("none_busy", 64'(busy), 64'd0);
         chk("none_ready", 64'(commit_ready), 64'd1);
         chk("none_count", 64'(trap_count), 64'(exp_cnt));
         return;
      end

      for (int i = 0; i <= nbusy; i++) begin
         scramble_commit();
         mem_busy = (i < nbusy);
         #1;
         chk("drain_flush", 64'(flush), 64'd1);
         chk("drain_ready", 64'(commit_ready), 64'd0);
         chk("drain_kill", 64'(commit_kill), 64'd0);
         chk("drain_strobe", 64'({csr_trap_enter, csr_trap_ret}), 64'd0);
         chk("drain_rvalid", 64'(redirect_valid), 64'd0);
         step();
      end

      scramble_commit();
      mem_busy = 1'($urandom_range(0, 1));
      #1;
      exp_cause = (ev == 1) ? CAUSE_IRQ : (ev == 2) ? CAUSE_ECALL : 64'd0;
      exp_tgt   = (ev == 3) ? mepc : mtvec - (mtvec % 4);
      chk("upd_enter", 64'(csr_trap_enter), 64'(ev != 3));
      chk("upd_ret", 64'(csr_trap_ret), 64'(ev == 3));
      chk("upd_mepc", csr_mepc_wdata, (ev != 3) ? pc : 64'd0);
      chk("upd_mcause", csr_mcause_wdata, exp_cause);
      chk("upd_flush", 64'(flush), 64'd1);
      chk("upd_rvalid", 64'(redirect_valid), 64'd0);
      if (ev != 3) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      step();

      for (int k = 0; k <= ndelay; k++) begin
         scramble_commit();
         redirect_ready = (k == ndelay);
         mtvec_i = rnd64();
         mepc_i  = rnd64();
         #1;
         chk("rd_valid", 64'(redirect_valid), 64'd1);
         chk("rd_pc", redirect_pc, exp_tgt);
         chk("rd_flush", 64'(flush), 64'd0);
         chk("rd_strobe", 64'({csr_trap_enter, csr_trap_ret}), 64'd0);
         chk("rd_count", 64'(trap_count), 64'(exp_cnt));
         step();
      end

      commit_valid = 1'b0; redirect_ready = 1'b0; mem_busy = 1'b0;
      #1;
      chk("end_rvalid", 64'(redirect_valid), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_ready", 64'(commit_ready), 64'd1);
      chk("end_count", 64'(trap_count), 64'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_ecall = 1'b0;
      commit_mret = 1'b0; irq_pending = 1'b0; mem_busy = 1'b0;
      mtvec_i = '0; mepc_i = '0; redirect_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_ready", 64'(commit_ready), 64'd1);
      chk("rst_outs", 64'({commit_kill, flush, csr_trap_enter, csr_trap_ret, redirect_valid, busy}), 64'd0);
      chk("rst_wdata", csr_mepc_wdata | csr_mcause_wdata | redirect_pc, 64'd0);
      chk("rst_count", 64'(trap_count), 64'd0);
      step();

      // ecall, immediate drain and ready
      run_txn(64'h8000_0100, 1'b1, 1'b0, 1'b0, 0, 0, 64'h8000_0004, 64'h0);
      chk("ecall_count", 64'(trap_count), 64'd1);
      step();
      // irq beats ecall on the same instruction; mtvec low bits masked
      run_txn(64'h8000_0200, 1'b1, 1'b0, 1'b1, 0, 0, 64'h8000_0007, 64'h0);
      step();
      // irq with pc 0 is not taken
      run_txn(64'h0, 1'b0, 1'b0, 1'b1, 0, 0, 64'h8000_0004, 64'h0);
      step();
      // mret with a 3-cycle drain
      run_txn(64'h8000_0300, 1'b0, 1'b1, 1'b0, 3, 0, 64'h8000_0004, 64'h8000_0204);
      // redirect_ready held low 5 cycles
      run_txn(64'h8000_0400, 1'b1, 1'b0, 1'b0, 1, 5, 64'h8000_1000, 64'h0);
      // enough ecalls to wrap the narrow counter
      for (int n = 0; n < 14; n++)
         run_txn(64'h8000_0500 + 64'(n * 4), 1'b1, 1'b0, 1'b0, 0, 0, 64'h8000_2000, 64'h0);

      // reset during DRAIN
      commit_valid = 1'b1; commit_pc = 64'h8000_0600; commit_ecall = 1'b1;
      commit_mret = 1'b0; irq_pending = 1'b0; mem_busy = 1'b1;
      step();
      commit_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; mem_busy = 1'b0;
      #1;
      exp_cnt = 0;
      chk("rstd_busy", 64'(busy), 64'd0);
      chk("rstd_ready", 64'(commit_ready), 64'd1);
      chk("rstd_strobe", 64'({csr_trap_enter, csr_trap_ret}), 64'd0);
      chk("rstd_count", 64'(trap_count), 64'd0);
      step();
      chk("rstd_nostrobe", 64'({csr_trap_enter, csr_trap_ret}), 64'd0);

      // reset during REDIRECT
      commit_valid = 1'b1; commit_ecall = 1'b0; commit_mret = 1'b1; mepc_i = 64'h8000_0700;
      step();
      commit_valid = 1'b0;
      step(); step();
      #1;
      chk("rstr_valid_pre", 64'(redirect_valid), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rstr_valid_post", 64'(redirect_valid), 64'd0);
      chk("rstr_busy", 64'(busy), 64'd0);
      step();

      // randomized transactions
      for (int r = 0; r < 40; r++) begin
         logic [63:0] pc;
         pc = ($urandom_range(0, 3) == 0) ? 64'd0 : rnd64();
         run_txn(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd64(), rnd64());
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry (ecall, timer interrupt) and trap return (mret) for the pipelined core.
- Sits between the commit stage, the CSR file, the fetch unit and the LSU.
- Decides which event is taken, stalls commit and flushes the pipeline, then waits for the LSU to drain.
- Issues exactly one CSR update strobe, then redirects fetch to mtvec or mepc through a valid/ready handshake.

Parameters:
XLEN, 64, data/PC width
MCAUSE_IRQ, 64'h8000_0000_0000_0007, mcause for machine timer interrupt
MCAUSE_ECALL, 64'd11, mcause for ecall from M-mode
CNT_W, 32, width of trap_count

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high (already decided)
commit_valid  in  1  instruction present at commit
commit_ready  out  1  controller can accept a commit event (state==IDLE)
commit_pc  in  XLEN  PC of the instruction at commit
commit_ecall  in  1  commit instruction is ecall
commit_mret  in  1  commit instruction is mret
irq_pending  in  1  timer interrupt pending and enabled (mtie&mtip&mstatus.MIE, pre-gated)
commit_kill  out  1  squash commit instruction: no retire, no regfile write
flush  out  1  flush all stages younger than commit
mem_busy  in  1  LSU has an outstanding access
csr_trap_enter  out  1  one-cycle strobe: CSR saves mstatus, writes mepc/mcause
csr_trap_ret  out  1  one-cycle strobe: CSR performs mret mstatus update
csr_mepc_wdata  out  XLEN  mepc value, valid with csr_trap_enter
csr_mcause_wdata  out  XLEN  mcause value, valid with csr_trap_enter
mtvec_i  in  XLEN  current mtvec
mepc_i  in  XLEN  current mepc
redirect_valid  out  1  fetch redirect request
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  redirect target
busy  out  1  state != IDLE
trap_count  out  CNT_W  number of trap entries taken; wraps

Behaviour:
- States: IDLE, DRAIN, UPDATE, REDIRECT. Reset forces IDLE and clears every latch and trap_count; all outputs read 0 except commit_ready=1.
- Event detection happens only in IDLE when commit_valid=1. Priority, highest first:
  - IRQ: irq_pending & commit_pc!=0.
  - ECALL: commit_ecall.
  - MRET: commit_mret.
  - Otherwise no event; the instruction retires normally.
- Detection cycle T, all combinational:
  - flush=1 for every event.
  - commit_kill=1 for IRQ and ECALL. The interrupted or ecall instruction does not retire.
  - commit_kill=0 for MRET; mret retires.
  - IRQ beats ecall/mret on the same instruction; that instruction is re-executed after return.
- Latch at T:
  - event type.
  - epc = commit_pc.
  - cause = MCAUSE_IRQ or MCAUSE_ECALL.
- Next state is always DRAIN.
- DRAIN:
  - flush=1 and commit_ready=0.
  - Remain while mem_busy=1; move to UPDATE on the first cycle mem_busy=0.
  - No time limit.
- UPDATE, exactly one cycle:
  - IRQ/ECALL: csr_trap_enter=1, csr_mepc_wdata=epc, csr_mcause_wdata=cause. Capture target={mtvec_i[XLEN-1:2],2'b00} (direct mode only). trap_count+=1.
  - MRET: csr_trap_ret=1. Capture target=mepc_i.
  - Both cases: flush=1, then go to REDIRECT.
- REDIRECT:
  - redirect_valid=1 with redirect_pc=target; flush=0.
  - redirect_pc is stable while valid.
  - Handshake completes in the cycle redirect_valid & redirect_ready, then go to IDLE.
  - redirect_ready high in the first REDIRECT cycle gives a one-cycle REDIRECT.
- Total latency with no drain wait and immediate ready: T to IDLE = 4 cycles (T, DRAIN, UPDATE, REDIRECT).
- Outside IDLE, commit_valid, commit_ecall, commit_mret and irq_pending are ignored. The commit stage must hold while commit_ready=0. An irq arriving mid-sequence is re-evaluated at the next IDLE commit.
- Outside UPDATE, csr_trap_enter/csr_trap_ret are 0 and csr_*_wdata are 0.
- Reset mid-sequence: the in-flight event is dropped, no CSR strobe is issued, and redirect_valid drops on the next edge.
- trap_count wraps from 2^CNT_W-1 to 0. It counts IRQ and ECALL entries, not MRET.

Decomposition:
- Shared package: state encoding (2-bit enum), event-type encoding (NONE/IRQ/ECALL/MRET), MCAUSE constants, mtvec alignment mask.
- No sub-module. A single FSM plus latches is natural; the trap_count counter stays inline.

Test Plan:
- ecall at commit_pc=0x8000_0100, mtvec_i=0x8000_0004, mem_busy=0, redirect_ready=1 → commit_kill=1 at T; UPDATE strobe csr_trap_enter with mepc=0x8000_0100, mcause=11; redirect_pc=0x8000_0004 one cycle later; trap_count=1.
- irq_pending=1 and commit_ecall=1 same cycle at pc=0x8000_0200 → IRQ taken, mcause=0x8000_0000_0000_0007, mepc=0x8000_0200, no ECALL entry.
- irq_pending=1 with commit_pc=0 → no event; commit_kill=0, flush=0, state stays IDLE.
- mret with mepc_i=0x8000_0204, mem_busy high 3 cycles → DRAIN 3 cycles, csr_trap_ret 1 cycle, redirect_pc=0x8000_0204; commit_kill=0; trap_count unchanged.
- redirect_ready held low 5 cycles → redirect_valid and redirect_pc stable for 5 cycles, IDLE the cycle after ready.
- rst asserted during DRAIN → next cycle IDLE, commit_ready=1, no csr strobe, trap_count=0.
